// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem request/ack handshake,
// squashes redirected fetches and skids one word while the pipeline is paused.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        pause,
    input  logic        redirect_i,
    input  logic [31:0] pc_next_i,
    input  logic        ins_clr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic        ins_valid_o,
    output logic        fetch_busy_o,
    output logic [31:0] clk_cnt_o,
    output logic [31:0] ins_cnt_o
);

    // Handshake: imem_req_o is held with a stable imem_addr_o until the cycle in
    // which imem_ack_i is high; that cycle completes the transfer and imem_data_i
    // is sampled on its closing edge. Dropping req without ack only happens on reset.

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] skid_ins_q, skid_ins_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        squash_q, squash_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] clk_cnt_q;
    logic [31:0] ins_cnt_q;
    logic        deliver;
    logic [31:0] tgt;

    assign tgt          = {pc_next_i[31:2], 2'b00};
    assign imem_req_o   = (state_q == FETCH) && !rst_i;
    assign imem_addr_o  = {fpc_q[31:2], 2'b00};
    assign fetch_busy_o = imem_req_o && !imem_ack_i;

    assign ins_o       = ins_q;
    assign pc_o        = pc_q;
    assign ins_valid_o = valid_q;
    assign clk_cnt_o   = clk_cnt_q;
    assign ins_cnt_o   = ins_cnt_q;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        skid_ins_d = skid_ins_q;
        skid_pc_d  = skid_pc_q;
        squash_d   = squash_q;
        pend_tgt_d = pend_tgt_q;
        ins_d      = ins_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        deliver    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack_i) begin
                    if (squash_q || redirect_i) begin
                        // A redirect on the ack cycle itself beats the pending target.
                        fpc_d    = redirect_i ? tgt : pend_tgt_q;
                        squash_d = 1'b0;
                        if (!pause) begin
                            ins_d   = NOP_INS;
                            valid_d = 1'b0;
                        end
                    end else begin
                        fpc_d = fpc_q + 32'd4;
                        if (pause) begin
                            skid_ins_d = imem_data_i;
                            skid_pc_d  = imem_addr_o;
                            state_d    = HOLD;
                        end else if (ins_clr_i) begin
                            ins_d   = NOP_INS;
                            valid_d = 1'b0;
                        end else begin
                            ins_d   = imem_data_i;
                            pc_d    = imem_addr_o;
                            valid_d = 1'b1;
                            deliver = 1'b1;
                        end
                    end
                end else begin
                    if (redirect_i) begin
                        squash_d   = 1'b1;
                        pend_tgt_d = tgt;
                    end
                    // Memory wait with the pipeline running: present a bubble.
                    if (!pause) begin
                        valid_d = 1'b0;
                        if (ins_clr_i) begin
                            ins_d = NOP_INS;
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    fpc_d   = tgt;
                    state_d = FETCH;
                    if (!pause) begin
                        ins_d   = NOP_INS;
                        valid_d = 1'b0;
                    end
                end else if (!pause) begin
                    state_d = FETCH;
                    if (ins_clr_i) begin
                        ins_d   = NOP_INS;
                        valid_d = 1'b0;
                    end else begin
                        ins_d   = skid_ins_q;
                        pc_d    = skid_pc_q;
                        valid_d = 1'b1;
                        deliver = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_PC;
            skid_ins_q <= NOP_INS;
            skid_pc_q  <= RESET_PC;
            squash_q   <= 1'b0;
            pend_tgt_q <= RESET_PC;
            ins_q      <= NOP_INS;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            clk_cnt_q  <= 32'd0;
            ins_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            skid_ins_q <= skid_ins_d;
            skid_pc_q  <= skid_pc_d;
            squash_q   <= squash_d;
            pend_tgt_q <= pend_tgt_d;
            ins_q      <= ins_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            clk_cnt_q  <= clk_cnt_q + 32'd1;
            if (deliver) begin
                ins_cnt_q <= ins_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted memory responses per scenario, expected
// instruction/pc pairs queued when an ack is driven and compared on delivery.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pause;
    logic        redirect_i;
    logic [31:0] pc_next_i;
    logic        ins_clr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] ins_o;
    logic [31:0] pc_o;
    logic        ins_valid_o;
    logic        fetch_busy_o;
    logic [31:0] clk_cnt_o;
    logic [31:0] ins_cnt_o;

    localparam logic [31:0] NOP = 32'h0000_0000;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INS (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .pause       (pause),
        .redirect_i  (redirect_i),
        .pc_next_i   (pc_next_i),
        .ins_clr_i   (ins_clr_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .ins_o       (ins_o),
        .pc_o        (pc_o),
        .ins_valid_o (ins_valid_o),
        .fetch_busy_o(fetch_busy_o),
        .clk_cnt_o   (clk_cnt_o),
        .ins_cnt_o   (ins_cnt_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] clk_exp = 0;
    logic [31:0] ins_exp = 0;
    logic [31:0] exp_addr = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
    endfunction

    // Advance one clock; track the expected cycle counter from the sampled reset.
    task automatic tick();
        logic r;
        r = rst_i;
        @(posedge clk);
        #1;
        if (r) clk_exp = 0;
        else clk_exp = clk_exp + 1;
    endtask

    task automatic set_in(input logic ack, input logic [31:0] data, input logic p,
                          input logic rd, input logic [31:0] tgt, input logic clr);
        imem_ack_i  = ack;
        imem_data_i = data;
        pause       = p;
        redirect_i  = rd;
        pc_next_i   = tgt;
        ins_clr_i   = clr;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        n_cmp++; if (fetch_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", fetch_busy_o); end
        n_cmp++; if (ins_o !== NOP) begin n_err++; $display("FAIL reset_ins got=%h exp=%h", ins_o, NOP); end
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        n_cmp++; if (ins_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ins_valid_o); end
        n_cmp++; if (clk_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_clk_cnt got=%0d exp=0", clk_cnt_o); end
        n_cmp++; if (ins_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_ins_cnt got=%0d exp=0", ins_cnt_o); end
    endtask

    task automatic test_sequential(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1, mem_word(exp_addr), 0, 0, 0, 0);
            n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL seq_req got=%b exp=1", imem_req_o); end
            n_cmp++; if (imem_addr_o !== exp_addr) begin n_err++; $display("FAIL seq_addr got=%h exp=%h", imem_addr_o, exp_addr); end
            n_cmp++; if (fetch_busy_o !== 1'b0) begin n_err++; $display("FAIL seq_busy got=%b exp=0", fetch_busy_o); end
            exp_q.push_back({mem_word(exp_addr), exp_addr});
            ins_exp = ins_exp + 1;
            exp_addr = exp_addr + 4;
            tick();
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL seq_queue got=empty exp=entry");
            end else begin
                exp = exp_q.pop_front();
                n_cmp++; if (ins_o !== exp[63:32]) begin n_err++; $display("FAIL seq_ins got=%h exp=%h", ins_o, exp[63:32]); end
                n_cmp++; if (pc_o !== exp[31:0]) begin n_err++; $display("FAIL seq_pc got=%h exp=%h", pc_o, exp[31:0]); end
            end
            n_cmp++; if (ins_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid got=%b exp=1", ins_valid_o); end
            n_cmp++; if (ins_cnt_o !== ins_exp) begin n_err++; $display("FAIL seq_ins_cnt got=%0d exp=%0d", ins_cnt_o, ins_exp); end
            n_cmp++; if (clk_cnt_o !== clk_exp) begin n_err++; $display("FAIL seq_clk_cnt got=%0d exp=%0d", clk_cnt_o, clk_exp); end
        end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            n_cmp++; if (fetch_busy_o !== 1'b1) begin n_err++; $display("FAIL wait_busy got=%b exp=1", fetch_busy_o); end
            n_cmp++; if (imem_addr_o !== 32'h10) begin n_err++; $display("FAIL wait_addr got=%h exp=10", imem_addr_o); end
            tick();
        end
        test_sequential(1);
    endtask

    task automatic test_redirect();
        set_in(0, 0, 0, 1, 32'h200, 0);
        n_cmp++; if (fetch_busy_o !== 1'b1) begin n_err++; $display("FAIL redir_busy got=%b exp=1", fetch_busy_o); end
        tick();
        set_in(0, 0, 0, 1, 32'h403, 0);
        n_cmp++; if (imem_addr_o !== 32'h14) begin n_err++; $display("FAIL redir_addr_hold1 got=%h exp=14", imem_addr_o); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_addr_o !== 32'h14) begin n_err++; $display("FAIL redir_addr_hold2 got=%h exp=14", imem_addr_o); end
        tick();
        set_in(1, mem_word(32'h14), 0, 0, 0, 0);
        n_cmp++; if (imem_addr_o !== 32'h14) begin n_err++; $display("FAIL redir_addr_ack got=%h exp=14", imem_addr_o); end
        tick();
        n_cmp++; if (ins_o !== NOP) begin n_err++; $display("FAIL redir_drop_ins got=%h exp=%h", ins_o, NOP); end
        n_cmp++; if (ins_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_drop_valid got=%b exp=0", ins_valid_o); end
        n_cmp++; if (ins_cnt_o !== ins_exp) begin n_err++; $display("FAIL redir_ins_cnt got=%0d exp=%0d", ins_cnt_o, ins_exp); end
        // Redirect on the ack cycle itself.
        set_in(1, mem_word(32'h400), 0, 1, 32'h1C, 0);
        n_cmp++; if (imem_addr_o !== 32'h400) begin n_err++; $display("FAIL redir_target got=%h exp=400", imem_addr_o); end
        tick();
        n_cmp++; if (ins_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_ack_valid got=%b exp=0", ins_valid_o); end
        exp_addr = 32'h1C;
    endtask

    task automatic test_pause();
        test_sequential(1);
        set_in(1, 32'hDEADBEEF, 1, 0, 0, 0);
        n_cmp++; if (imem_addr_o !== 32'h20) begin n_err++; $display("FAIL pause_addr got=%h exp=20", imem_addr_o); end
        exp_q.push_back({32'hDEADBEEF, 32'h20});
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0, 0);
            n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL hold_req got=%b exp=0", imem_req_o); end
            n_cmp++; if (ins_o !== mem_word(32'h1C)) begin n_err++; $display("FAIL hold_ins got=%h exp=%h", ins_o, mem_word(32'h1C)); end
            n_cmp++; if (pc_o !== 32'h1C) begin n_err++; $display("FAIL hold_pc got=%h exp=1c", pc_o); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL release_req got=%b exp=0", imem_req_o); end
        tick();
        ins_exp = ins_exp + 1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL release_queue got=empty exp=entry");
        end else begin
            exp = exp_q.pop_front();
            n_cmp++; if (ins_o !== exp[63:32]) begin n_err++; $display("FAIL release_ins got=%h exp=%h", ins_o, exp[63:32]); end
            n_cmp++; if (pc_o !== exp[31:0]) begin n_err++; $display("FAIL release_pc got=%h exp=%h", pc_o, exp[31:0]); end
        end
        n_cmp++; if (ins_valid_o !== 1'b1) begin n_err++; $display("FAIL release_valid got=%b exp=1", ins_valid_o); end
        n_cmp++; if (ins_cnt_o !== ins_exp) begin n_err++; $display("FAIL release_ins_cnt got=%0d exp=%0d", ins_cnt_o, ins_exp); end
        exp_addr = 32'h24;
    endtask

    task automatic test_clear();
        set_in(1, 32'h12345678, 0, 0, 0, 1);
        n_cmp++; if (imem_addr_o !== 32'h24) begin n_err++; $display("FAIL clr_addr got=%h exp=24", imem_addr_o); end
        tick();
        n_cmp++; if (ins_o !== NOP) begin n_err++; $display("FAIL clr_ins got=%h exp=%h", ins_o, NOP); end
        n_cmp++; if (ins_valid_o !== 1'b0) begin n_err++; $display("FAIL clr_valid got=%b exp=0", ins_valid_o); end
        n_cmp++; if (ins_cnt_o !== ins_exp) begin n_err++; $display("FAIL clr_ins_cnt got=%0d exp=%0d", ins_cnt_o, ins_exp); end
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_addr_o !== 32'h28) begin n_err++; $display("FAIL clr_next_addr got=%h exp=28", imem_addr_o); end
        tick();
        exp_addr = 32'h28;
    endtask

    task automatic test_back_to_back();
        logic ack;
        for (int i = 0; i < 24; i++) begin
            ack = 1'($urandom_range(0, 1));
            set_in(ack, mem_word(exp_addr), 0, 0, 0, 0);
            n_cmp++; if (imem_addr_o !== exp_addr) begin n_err++; $display("FAIL b2b_addr got=%h exp=%h", imem_addr_o, exp_addr); end
            if (ack) begin
                exp_q.push_back({mem_word(exp_addr), exp_addr});
                ins_exp = ins_exp + 1;
                exp_addr = exp_addr + 4;
            end
            tick();
            if (ack) begin
                exp = exp_q.pop_front();
                n_cmp++; if (ins_o !== exp[63:32]) begin n_err++; $display("FAIL b2b_ins got=%h exp=%h", ins_o, exp[63:32]); end
                n_cmp++; if (pc_o !== exp[31:0]) begin n_err++; $display("FAIL b2b_pc got=%h exp=%h", pc_o, exp[31:0]); end
            end
            n_cmp++; if (ins_cnt_o !== ins_exp) begin n_err++; $display("FAIL b2b_ins_cnt got=%0d exp=%0d", ins_cnt_o, ins_exp); end
        end
        n_cmp++; if (clk_cnt_o !== clk_exp) begin n_err++; $display("FAIL b2b_clk_cnt got=%0d exp=%0d", clk_cnt_o, clk_exp); end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 1, 32'h800, 0);
        n_cmp++; if (fetch_busy_o !== 1'b1) begin n_err++; $display("FAIL rmid_busy got=%b exp=1", fetch_busy_o); end
        tick();
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_req got=%b exp=0", imem_req_o); end
        n_cmp++; if (fetch_busy_o !== 1'b0) begin n_err++; $display("FAIL rmid_busy_rst got=%b exp=0", fetch_busy_o); end
        tick();
        ins_exp = 0;
        exp_q.delete();
        n_cmp++; if (clk_cnt_o !== 32'd0) begin n_err++; $display("FAIL rmid_clk_cnt got=%0d exp=0", clk_cnt_o); end
        n_cmp++; if (ins_cnt_o !== 32'd0) begin n_err++; $display("FAIL rmid_ins_cnt got=%0d exp=0", ins_cnt_o); end
        n_cmp++; if (ins_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", ins_valid_o); end
        rst_i = 1'b0;
        exp_addr = 32'h0;
        test_sequential(2);
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        test_reset();
        rst_i = 1'b0;
        exp_addr = 32'h0;
        test_sequential(4);
        test_wait();
        test_redirect();
        test_pause();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
